// File: rtl/pipe_backbone_if.sv
// Handshake and observation bundle between fetch, the pipeline backbone and writeback.
// The backbone uses the slave modport; the surrounding datapath or bench uses master.
interface pipe_backbone_if #(
  parameter int unsigned STAGES = 5,
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned CNT_W  = 32
);
  logic                      in_valid;
  logic [WIDTH-1:0]          in_data;
  logic                      in_ready;
  logic [STAGES-1:0]         stall_req;
  logic                      exc_req;
  logic [STAGES-1:0]         stage_valid;
  logic [STAGES*WIDTH-1:0]   stage_data;
  logic                      retire_valid;
  logic [WIDTH-1:0]          retire_data;
  logic                      exc_taken;
  logic [WIDTH-1:0]          exc_data;
  logic [CNT_W-1:0]          stall_cycles;
  logic [CNT_W-1:0]          flush_count;

  modport master (
    output in_valid, in_data, stall_req, exc_req,
    input  in_ready, stage_valid, stage_data, retire_valid, retire_data,
           exc_taken, exc_data, stall_cycles, flush_count
  );

  modport slave (
    input  in_valid, in_data, stall_req, exc_req,
    output in_ready, stage_valid, stage_data, retire_valid, retire_data,
           exc_taken, exc_data, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipe_backbone.sv
// Parametrised pipeline skeleton: valid/payload chain with centralised stall and flush
// resolution, a precise-exception flush point and saturating stall/flush counters.
module pipe_backbone #(
  parameter int unsigned STAGES    = 5,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned EXC_STAGE = 2,
  parameter int unsigned CNT_W     = 32
) (
  input logic            clk,
  input logic            rst,
  pipe_backbone_if.slave bus
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [STAGES-1:0]            valid_q, valid_d;
  logic [STAGES-1:0][WIDTH-1:0] data_q, data_d;
  logic [STAGES-1:0]            hold;
  logic                         exc_eff;
  logic                         stall_inc;
  logic                         exc_taken_q;
  logic [WIDTH-1:0]             exc_data_q, exc_data_d;
  logic [CNT_W-1:0]             stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]             flush_cnt_q, flush_cnt_d;

  // hold[k] is set when any stage at or above k requests a stall, i.e. k <= J.
  always_comb begin
    hold = '0;
    hold[STAGES-1] = bus.stall_req[STAGES-1];
    for (int k = int'(STAGES) - 2; k >= 0; k--) begin
      hold[k] = hold[k+1] | bus.stall_req[k];
    end
  end

  // The exception waits while its own stage or any older stage is stalled.
  assign exc_eff   = bus.exc_req & valid_q[EXC_STAGE] & ~hold[EXC_STAGE];
  assign stall_inc = hold[0] & ~exc_eff;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (exc_eff) begin
      // Kill stages up to and including EXC_STAGE, bubble the one above, drain the rest.
      valid_d[0] = 1'b0;
      for (int k = 1; k < int'(STAGES); k++) begin
        if (k <= int'(EXC_STAGE) + 1) begin
          valid_d[k] = 1'b0;
        end else begin
          valid_d[k] = valid_q[k-1];
          data_d[k]  = data_q[k-1];
        end
      end
    end else begin
      if (!hold[0]) begin
        valid_d[0] = bus.in_valid;
        data_d[0]  = bus.in_data;
      end
      for (int k = 1; k < int'(STAGES); k++) begin
        if (!hold[k]) begin
          if (hold[k-1]) begin
            valid_d[k] = 1'b0;
          end else begin
            valid_d[k] = valid_q[k-1];
            data_d[k]  = data_q[k-1];
          end
        end
      end
    end
  end

  always_comb begin
    exc_data_d  = exc_eff ? data_q[EXC_STAGE] : exc_data_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc && (stall_cnt_q != CntMax)) begin
      stall_cnt_d = stall_cnt_q + CntOne;
    end
    if (exc_eff && (flush_cnt_q != CntMax)) begin
      flush_cnt_d = flush_cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      data_q      <= '0;
      exc_taken_q <= 1'b0;
      exc_data_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      data_q      <= data_d;
      exc_taken_q <= exc_eff;
      exc_data_q  <= exc_data_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.in_ready     = ~hold[0] & ~exc_eff;
  assign bus.stage_valid  = valid_q;
  assign bus.stage_data   = data_q;
  assign bus.retire_valid = valid_q[STAGES-1] & ~bus.stall_req[STAGES-1];
  assign bus.retire_data  = data_q[STAGES-1];
  assign bus.exc_taken    = exc_taken_q;
  assign bus.exc_data     = exc_data_q;
  assign bus.stall_cycles = stall_cnt_q;
  assign bus.flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_pipe_backbone.sv
// Self-checking bench for pipe_backbone: retire-order scoreboard plus per-scenario checks
// on stalls, flushes, counter saturation (second instance with 4-bit counters) and reset.
module tb_pipe_backbone;
  localparam int unsigned STAGES = 5;
  localparam int unsigned WIDTH  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_backbone_if #(.STAGES(STAGES), .WIDTH(WIDTH), .CNT_W(32)) bus ();
  pipe_backbone_if #(.STAGES(STAGES), .WIDTH(WIDTH), .CNT_W(4))  bus4 ();

  pipe_backbone #(.STAGES(STAGES), .WIDTH(WIDTH), .EXC_STAGE(2), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pipe_backbone #(.STAGES(STAGES), .WIDTH(WIDTH), .EXC_STAGE(2), .CNT_W(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  int vectors     = 0;
  int miscompares = 0;
  logic [WIDTH-1:0] sb[$];

  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic [STAGES-1:0] st,
                       input logic e);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.stall_req = st;
    bus.exc_req   = e;
    #1;
  endtask

  // Scoreboard: pop on retirement (older first), push on acceptance, then advance one edge.
  task automatic adv();
    logic [WIDTH-1:0] exp;
    if (!rst) begin
      if (bus.retire_valid) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL retire_order: got retirement of %h, required none", bus.retire_data);
        end else begin
          exp = sb.pop_front();
          if (bus.retire_data !== exp) begin
            miscompares++;
            $display("FAIL retire_order: got %h, required %h", bus.retire_data, exp);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) sb.push_back(bus.in_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, '0, '0, 1'b0);
      adv();
    end
  endtask

  task automatic kill(input logic [WIDTH-1:0] val);
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i] == val) sb.delete(i);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    adv();
    adv();
    rst = 1'b0;
    vectors++;
    if (bus.stage_valid !== '0 || bus.stage_data !== '0) begin
      miscompares++;
      $display("FAIL reset_stages: got valid %b data %h, required all zero",
               bus.stage_valid, bus.stage_data);
    end
    vectors++;
    if (bus.exc_taken !== 1'b0 || bus.exc_data !== '0) begin
      miscompares++;
      $display("FAIL reset_exc: got taken %b data %h, required 0/0", bus.exc_taken, bus.exc_data);
    end
    vectors++;
    if (bus.stall_cycles !== '0 || bus.flush_count !== '0 || bus4.stall_cycles !== '0) begin
      miscompares++;
      $display("FAIL reset_counters: got %0d/%0d/%0d, required 0/0/0",
               bus.stall_cycles, bus.flush_count, bus4.stall_cycles);
    end
  endtask

  task automatic test_streaming();
    logic exp_rv;
    for (int s = 0; s < 14; s++) begin
      drive(s < 8, WIDTH'(s + 1), '0, 1'b0);
      vectors++;
      if (bus.in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL stream_ready step %0d: got %b, required 1", s, bus.in_ready);
      end
      exp_rv = (s >= 5) && (s <= 12);
      vectors++;
      if (bus.retire_valid !== exp_rv || (exp_rv && bus.retire_data !== WIDTH'(s - 4))) begin
        miscompares++;
        $display("FAIL stream_latency step %0d: got %b/%h, required %b/%h", s,
                 bus.retire_valid, bus.retire_data, exp_rv, WIDTH'(s - 4));
      end
      adv();
    end
    vectors++;
    if (bus.stall_cycles !== 32'd0) begin
      miscompares++;
      $display("FAIL stream_stall_cycles: got %0d, required 0", bus.stall_cycles);
    end
  endtask

  task automatic test_stall();
    int nxt = 1, accepted = 0, retired = 0, bubbles = 0;
    logic seen = 1'b0;
    logic stall;
    logic [2*WIDTH-1:0] snap;
    logic [1:0] snapv;
    for (int s = 0; s < 24; s++) begin
      stall = (s >= 3) && (s <= 5);
      drive(accepted < 8, WIDTH'(32'h100 + nxt), stall ? 5'b00010 : 5'b00000, 1'b0);
      vectors++;
      if (bus.in_ready !== !stall) begin
        miscompares++;
        $display("FAIL stall_ready step %0d: got %b, required %b", s, bus.in_ready, !stall);
      end
      if (s == 3) begin
        snap  = bus.stage_data[2*WIDTH-1:0];
        snapv = bus.stage_valid[1:0];
      end
      if (s >= 4 && s <= 6) begin
        vectors++;
        if (bus.stage_data[2*WIDTH-1:0] !== snap || bus.stage_valid[1:0] !== snapv) begin
          miscompares++;
          $display("FAIL stall_frozen step %0d: got %h/%b, required %h/%b", s,
                   bus.stage_data[2*WIDTH-1:0], bus.stage_valid[1:0], snap, snapv);
        end
      end
      if (retired < 8) begin
        if (bus.retire_valid) begin
          retired++;
          seen = 1'b1;
        end else if (seen) begin
          bubbles++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        accepted++;
        nxt++;
      end
      adv();
    end
    vectors++;
    if (retired != 8 || bubbles != 3) begin
      miscompares++;
      $display("FAIL stall_bubbles: got %0d retired %0d bubbles, required 8 and 3",
               retired, bubbles);
    end
    vectors++;
    if (bus.stall_cycles !== 32'd3) begin
      miscompares++;
      $display("FAIL stall_cycles: got %0d, required 3", bus.stall_cycles);
    end
  endtask

  task automatic test_exc_flush();
    logic [WIDTH-1:0] seq [5] = '{32'h5, 32'h6, 32'hA, 32'hB, 32'hC};
    for (int s = 0; s < 5; s++) begin
      drive(1'b1, seq[s], '0, 1'b0);
      adv();
    end
    drive(1'b1, 32'hD, '0, 1'b1);
    vectors++;
    if (bus.stage_data[2*WIDTH +: WIDTH] !== 32'hA || bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL exc_setup: got stage2 %h ready %b, required 0000000a ready 0",
               bus.stage_data[2*WIDTH +: WIDTH], bus.in_ready);
    end
    adv();
    vectors++;
    if (bus.exc_taken !== 1'b1 || bus.exc_data !== 32'hA) begin
      miscompares++;
      $display("FAIL exc_taken: got %b/%h, required 1/0000000a", bus.exc_taken, bus.exc_data);
    end
    vectors++;
    if (bus.stage_valid !== 5'b10000 || bus.stage_data[4*WIDTH +: WIDTH] !== 32'h6) begin
      miscompares++;
      $display("FAIL exc_stages: got valid %b stage4 %h, required 10000 00000006",
               bus.stage_valid, bus.stage_data[4*WIDTH +: WIDTH]);
    end
    vectors++;
    if (bus.flush_count !== 32'd1 || bus.stall_cycles !== 32'd3) begin
      miscompares++;
      $display("FAIL exc_counters: got flush %0d stall %0d, required 1 and 3",
               bus.flush_count, bus.stall_cycles);
    end
    kill(32'hA);
    kill(32'hB);
    kill(32'hC);
    drive(1'b1, 32'hD, '0, 1'b0);
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL exc_reaccept: got %b, required 1", bus.in_ready);
    end
    adv();
    vectors++;
    if (bus.exc_taken !== 1'b0) begin
      miscompares++;
      $display("FAIL exc_pulse: got %b, required 0", bus.exc_taken);
    end
    for (int s = 0; s < 7; s++) begin
      drive(1'b0, '0, '0, 1'b0);
      if (bus.retire_valid && bus.retire_data == 32'hA) begin
        vectors++;
        miscompares++;
        $display("FAIL exc_killed_retired: got %h, required never", bus.retire_data);
      end
      adv();
    end
  endtask

  task automatic test_stall_vs_exc();
    for (int s = 0; s < 3; s++) begin
      drive(1'b1, WIDTH'(32'h21 + s), '0, 1'b0);
      adv();
    end
    for (int s = 0; s < 2; s++) begin
      drive(1'b0, '0, 5'b01000, 1'b1);
      vectors++;
      if (bus.in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL sve_ready cycle %0d: got %b, required 0", s, bus.in_ready);
      end
      adv();
      vectors++;
      if (bus.exc_taken !== 1'b0) begin
        miscompares++;
        $display("FAIL sve_no_flush cycle %0d: got %b, required 0", s, bus.exc_taken);
      end
    end
    drive(1'b0, '0, '0, 1'b1);
    vectors++;
    if (bus.in_ready !== 1'b0 || bus.stage_data[2*WIDTH +: WIDTH] !== 32'h21) begin
      miscompares++;
      $display("FAIL sve_pending: got ready %b stage2 %h, required 0 00000021",
               bus.in_ready, bus.stage_data[2*WIDTH +: WIDTH]);
    end
    adv();
    vectors++;
    if (bus.exc_taken !== 1'b1 || bus.exc_data !== 32'h21) begin
      miscompares++;
      $display("FAIL sve_flush: got %b/%h, required 1/00000021", bus.exc_taken, bus.exc_data);
    end
    vectors++;
    if (bus.stall_cycles !== 32'd5 || bus.flush_count !== 32'd2) begin
      miscompares++;
      $display("FAIL sve_counters: got stall %0d flush %0d, required 5 and 2",
               bus.stall_cycles, bus.flush_count);
    end
    kill(32'h21);
    kill(32'h22);
    kill(32'h23);
    drain(6);
  endtask

  task automatic test_saturation();
    int exp;
    for (int i = 0; i < 23; i++) begin
      bus4.stall_req = (i < 20) ? 5'b00001 : 5'b00000;
      drive(1'b0, '0, '0, 1'b0);
      adv();
      exp = (i + 1 < 15) ? i + 1 : 15;
      vectors++;
      if (bus4.stall_cycles !== 4'(exp)) begin
        miscompares++;
        $display("FAIL sat_stall_cycles step %0d: got %0d, required %0d", i,
                 bus4.stall_cycles, exp);
      end
    end
    vectors++;
    if (bus4.flush_count !== 4'd0) begin
      miscompares++;
      $display("FAIL sat_flush_count: got %0d, required 0", bus4.flush_count);
    end
  endtask

  task automatic test_midstream_reset();
    logic exp_rv;
    for (int s = 0; s < 4; s++) begin
      drive(1'b1, WIDTH'(32'h31 + s), '0, 1'b0);
      adv();
    end
    for (int s = 0; s < 2; s++) begin
      drive(1'b1, 32'h35, 5'b00100, 1'b0);
      adv();
    end
    drive(1'b1, 32'h35, '0, 1'b1);
    adv();
    vectors++;
    if (bus.exc_taken !== 1'b1 || bus.exc_data !== 32'h32) begin
      miscompares++;
      $display("FAIL mrst_preflush: got %b/%h, required 1/00000032", bus.exc_taken, bus.exc_data);
    end
    rst = 1'b1;
    drive(1'b1, 32'h35, 5'b00100, 1'b1);
    adv();
    rst = 1'b0;
    sb.delete();
    vectors++;
    if (bus.stage_valid !== '0 || bus.stage_data !== '0 || bus.exc_taken !== 1'b0 ||
        bus.exc_data !== '0) begin
      miscompares++;
      $display("FAIL mrst_state: got valid %b taken %b exc %h, required all zero",
               bus.stage_valid, bus.exc_taken, bus.exc_data);
    end
    vectors++;
    if (bus.stall_cycles !== '0 || bus.flush_count !== '0) begin
      miscompares++;
      $display("FAIL mrst_counters: got %0d/%0d, required 0/0", bus.stall_cycles,
               bus.flush_count);
    end
    for (int s = 0; s < 10; s++) begin
      drive(s < 4, WIDTH'(32'h41 + s), '0, 1'b0);
      exp_rv = (s >= 5) && (s <= 8);
      vectors++;
      if (bus.in_ready !== 1'b1 || bus.retire_valid !== exp_rv ||
          (exp_rv && bus.retire_data !== WIDTH'(32'h41 + s - 5))) begin
        miscompares++;
        $display("FAIL mrst_restart step %0d: got ready %b retire %b/%h, required 1 %b/%h", s,
                 bus.in_ready, bus.retire_valid, bus.retire_data, exp_rv,
                 WIDTH'(32'h41 + s - 5));
      end
      adv();
    end
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.stall_req  = '0;
    bus.exc_req    = 1'b0;
    bus4.in_valid  = 1'b0;
    bus4.in_data   = '0;
    bus4.stall_req = '0;
    bus4.exc_req   = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_streaming();
    drain(6);
    test_stall();
    drain(6);
    test_exc_flush();
    test_stall_vs_exc();
    test_saturation();
    test_midstream_reset();
    drain(6);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty: got %0d outstanding, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by 100000, required finish");
    $fatal(1, "timeout");
  end

endmodule
